div_iter_ctrl: RTL and testbench

//  Iterative 32-bit RV32M divide unit (DIV/DIVU/REM/REMU) for the execute stage.
//  It drives the shared ALU's operand/op interface as the initiator (src_a, src_b, alu_op out; alu_result in).

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/div_sign_fix.sv | 17 +
 rtl/riscv_alu.sv | 23 ++
 rtl/div_iter_ctrl.sv | 162 ++++++++++++++++
 tb/tb_div_iter_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 execute-stage encodings: ALU opcodes, M-extension divide ops, divider FSM states.
package riscv_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    localparam logic [2:0] DIV_ST_IDLE = 3'd0;
    localparam logic [2:0] DIV_ST_CMP  = 3'd1;
    localparam logic [2:0] DIV_ST_SUB  = 3'd2;
    localparam logic [2:0] DIV_ST_FIX  = 3'd3;
    localparam logic [2:0] DIV_ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = DIV_ST_IDLE,
        S_CMP  = DIV_ST_CMP,
        S_SUB  = DIV_ST_SUB,
        S_FIX  = DIV_ST_FIX,
        S_DONE = DIV_ST_DONE
    } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Two's-complement conditional negation of a Q/R pair; used for operand magnitudes
// on start and for the final signed fixup.
module div_sign_fix #(
    parameter int W = 32
) (
    input  logic         i_neg_q,
    input  logic         i_neg_r,
    input  logic [W-1:0] i_q,
    input  logic [W-1:0] i_r,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_r
);

    assign o_q = i_neg_q ? (~i_q + W'(1)) : i_q;
    assign o_r = i_neg_r ? (~i_r + W'(1)) : i_r;

endmodule

// File: rtl/riscv_alu.sv
// Shared execute-stage ALU subset used by the divider: ADD, SUB, SLT, SLTU.
// Purely combinational; result valid in the same cycle as the operands.
module riscv_alu
    import riscv_pkg::*;
(
    input  logic [3:0]  i_alu_op,
    input  logic [31:0] i_src_a,
    input  logic [31:0] i_src_b,
    output logic [31:0] o_alu_result
);

    always_comb begin
        o_alu_result = '0;
        case (i_alu_op)
            ALU_ADD:  o_alu_result = i_src_a + i_src_b;
            ALU_SUB:  o_alu_result = i_src_a - i_src_b;
            ALU_SLT:  o_alu_result = {31'd0, $signed(i_src_a) < $signed(i_src_b)};
            ALU_SLTU: o_alu_result = {31'd0, i_src_a < i_src_b};
            default:  o_alu_result = '0;
        endcase
    end

endmodule

// File: rtl/div_iter_ctrl.sv
// Iterative RV32M DIV/DIVU/REM/REMU: restoring division through the shared ALU, one bit per SLTU+SUB pair.
// Latency 66 cycles (1 for divide-by-zero/overflow; 2 for |a|<|b| when DIV_EARLY_OUT_EN is defined).
module div_iter_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] alu_src_a,
    output logic [XLEN-1:0] alu_src_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result
);

    div_state_t      r_state;
    logic [1:0]      r_op;
    logic            r_sign_a;
    logic            r_sign_b;
    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] r_r;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_cnt;
    logic            r_lt;
    logic            r_busy;
    logic            r_done;

    logic            w_idle;
    logic            w_sign_a;
    logic            w_sign_b;
    logic            w_div_zero;
    logic            w_ovf;
    logic [XLEN-1:0] w_rs;
    logic [XLEN-1:0] w_fix_q;
    logic [XLEN-1:0] w_fix_r;

    assign w_idle     = (r_state == S_IDLE);
    assign w_sign_a   = ~div_op[0] & dividend[XLEN-1];
    assign w_sign_b   = ~div_op[0] & divisor[XLEN-1];
    assign w_div_zero = (divisor == '0);
    assign w_ovf      = ~div_op[0] && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
    assign w_rs       = {r_r[XLEN-2:0], r_q[XLEN-1]};

    // In IDLE the negator yields |dividend| on o_q and |divisor| on o_r; in FIX it applies the sign fixup.
    div_sign_fix #(.W(XLEN)) u_sign_fix (
        .i_neg_q (w_idle ? w_sign_a : (r_sign_a ^ r_sign_b)),
        .i_neg_r (w_idle ? w_sign_b : r_sign_a),
        .i_q     (w_idle ? dividend : r_q),
        .i_r     (w_idle ? divisor  : r_r),
        .o_q     (w_fix_q),
        .o_r     (w_fix_r)
    );

    always_comb begin
        alu_op    = ALU_ADD;
        alu_src_a = '0;
        alu_src_b = '0;
        if (r_state == S_CMP || r_state == S_SUB) begin
            alu_op    = (r_state == S_CMP) ? ALU_SLTU : ALU_SUB;
            alu_src_a = w_rs;
            alu_src_b = r_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_q      <= '0;
            r_r      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_lt     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op     <= div_op;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_q      <= w_fix_q;
                        r_r      <= '0;
                        r_b      <= w_fix_r;
                        r_cnt    <= 5'(XLEN-1);
                        r_busy   <= 1'b1;
                        if (w_div_zero) begin
                            r_result <= div_op[1] ? dividend : '1;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else if (w_ovf) begin
                            r_result <= div_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
`ifdef DIV_EARLY_OUT_EN
                        end else if (w_fix_q < w_fix_r) begin
                            r_q     <= '0;
                            r_r     <= w_fix_q;
                            r_state <= S_FIX;
`endif
                        end else begin
                            r_state <= S_CMP;
                        end
                    end
                end
                S_CMP: begin
                    // A set R MSB means the shifted remainder exceeds 32 bits, so it is never below |b|.
                    r_lt    <= alu_result[0] & ~r_r[XLEN-1];
                    r_state <= S_SUB;
                end
                S_SUB: begin
                    r_r <= r_lt ? w_rs : alu_result;
                    r_q <= {r_q[XLEN-2:0], ~r_lt};
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt   <= r_cnt - 5'd1;
                        r_state <= S_CMP;
                    end
                end
                S_FIX: begin
                    r_result <= r_op[1] ? w_fix_r : w_fix_q;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_div_iter_ctrl.sv
// Randomized and directed bench for div_iter_ctrl against an arithmetic reference model.
// Latency expectations follow DIV_EARLY_OUT_EN when defined.
module tb_div_iter_ctrl;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  div_op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] alu_src_a;
    logic [31:0] alu_src_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    logic [31:0] last_res = '0;

    always #5 clk = ~clk;

    div_iter_ctrl #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .div_op     (div_op),
        .dividend   (dividend),
        .divisor    (divisor),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .alu_result (alu_result)
    );

    riscv_alu u_alu (
        .i_alu_op     (alu_op),
        .i_src_a      (alu_src_a),
        .i_src_b      (alu_src_b),
        .o_alu_result (alu_result)
    );

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint mag(input logic [1:0] op, input logic [31:0] x);
        longint v;
        if (op[0]) return longint'(x);
        v = longint'($signed(x));
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (mag(op, a) < mag(op, b)) return 2;
`endif
        return 66;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input bit chk_alu);
        logic [31:0] exp_res;
        int          exp_lat;
        int          n;
        bit          seen;
        exp_res = ref_result(op, a, b);
        exp_lat = ref_latency(op, a, b);
        @(negedge clk);
        start = 1'b1; div_op = op; dividend = a; divisor = b;
        @(posedge clk);
        #1 start = 1'b0;
        n = 1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) check({tag, "/busy"}, busy, 1);
            if (chk_alu && i == 0) begin
                check({tag, "/cmp_op"}, alu_op, ALU_SLTU);
                check({tag, "/cmp_b"}, alu_src_b, 64'(mag(op, b)));
            end
            if (chk_alu && i == 1) check({tag, "/sub_op"}, alu_op, ALU_SUB);
            if (done) begin
                seen = 1'b1;
                break;
            end
            n++;
        end
        check({tag, "/lat"}, seen ? n : 0, exp_lat);
        check({tag, "/res"}, result, exp_res);
        @(negedge clk);
        check({tag, "/done_drop"}, done, 0);
        check({tag, "/busy_drop"}, busy, 0);
        last_res = exp_res;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dc;
        logic [1:0]  op;
        logic [31:0] a, b;

        repeat (3) @(negedge clk);
        check("rst/busy", busy, 0);
        check("rst/done", done, 0);
        check("rst/result", result, 0);
        check("rst/alu_op", alu_op, ALU_ADD);
        check("rst/src_a", alu_src_a, 0);
        check("rst/src_b", alu_src_b, 0);
        rst_n = 1'b1;

        run_op(DIV_OP_DIVU, 32'd100, 32'd7, "divu100_7", 1'b1);
        run_op(DIV_OP_REMU, 32'd100, 32'd7, "remu100_7", 1'b0);
        run_op(DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, "div-7_2", 1'b1);
        run_op(DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, "rem-7_2", 1'b0);
        run_op(DIV_OP_DIV, 32'd12345, 32'd0, "div_x_0", 1'b0);
        run_op(DIV_OP_REM, 32'd5, 32'd0, "rem5_0", 1'b0);
        run_op(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0);
        run_op(DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 1'b0);
        run_op(DIV_OP_DIVU, 32'd3, 32'd10, "divu3_10", 1'b0);
        run_op(DIV_OP_REM, 32'd3, 32'hFFFF_FFF6, "rem3_-10", 1'b0);
        run_op(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "divu_big", 1'b0);
        run_op(DIV_OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, "remu_big", 1'b0);

        // Abort an operation at cycle 20, then run a fresh one.
        dc = done_cnt;
        @(negedge clk);
        start = 1'b1; div_op = DIV_OP_DIV; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush/busy", busy, 0);
        check("flush/done", done, 0);
        check("flush/result", result, last_res);
        repeat (70) @(negedge clk);
        check("flush/no_done", done_cnt, dc);
        run_op(DIV_OP_DIVU, 32'd9, 32'd3, "after_flush", 1'b0);

        // Flush and start together: start must be dropped.
        dc = done_cnt;
        @(negedge clk);
        start = 1'b1; flush = 1'b1; div_op = DIV_OP_DIVU; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_start/busy", busy, 0);
        repeat (70) @(negedge clk);
        check("flush_start/no_done", done_cnt, dc);

        // Start pulse while busy is ignored.
        dc = done_cnt;
        @(negedge clk);
        start = 1'b1; div_op = DIV_OP_DIVU; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 start = 1'b1; div_op = DIV_OP_REMU; dividend = 32'd5; divisor = 32'd0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (80) @(negedge clk);
        check("busy_start/one_done", done_cnt - dc, 1);
        check("busy_start/res", result, 32'd14);

        // Asynchronous reset in the middle of an iteration.
        @(negedge clk);
        start = 1'b1; div_op = DIV_OP_DIV; dividend = 32'hFFFF_FFF9; divisor = 32'd2;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst/busy", busy, 0);
        check("midrst/done", done, 0);
        check("midrst/result", result, 0);
        check("midrst/alu_op", alu_op, ALU_ADD);
        check("midrst/src_a", alu_src_a, 0);
        check("midrst/src_b", alu_src_b, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 40; k++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 40);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 20);
                2:       b = 32'hFFFF_FFFF;
                3:       b = $urandom >> $urandom_range(0, 31);
                4:       b = 32'h8000_0000 | $urandom;
                default: b = $urandom;
            endcase
            run_op(op, a, b, $sformatf("rnd%0d_op%0d", k, op), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
